// File: rtl/coupling_prog_ctrl_pkg.sv
// Shared definitions for the DIMPLE coupling-matrix programming sequencer:
// state encodings and the (source, destination) to column decode.
package coupling_prog_ctrl_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_WRITE  = 3'd2;
  localparam logic [2:0] S_HOLD   = 3'd3;
  localparam logic [2:0] S_RUN    = 3'd4;
  localparam logic [2:0] S_STOP   = 3'd5;
  localparam logic [2:0] S_VERIFY = 3'd6;

  typedef struct packed {
    logic        valid;
    logic [15:0] k;
  } col_dec_t;

  // Column index K = (d - s - 1) mod n; the d == s case would map to n-1,
  // which has no column, and is flagged invalid along with out-of-range ids.
  function automatic col_dec_t col_decode(input logic [15:0] s,
                                          input logic [15:0] d,
                                          input int          n);
    col_dec_t r;
    r.valid = (s != d) && (int'({16'd0, s}) < n) && (int'({16'd0, d}) < n);
    if (d > s) r.k = d - s - 16'd1;
    else       r.k = 16'(n) + d - s - 16'd1;
    return r;
  endfunction

endpackage

// File: rtl/coupling_prog_ctrl_sync_fifo.sv
// Single-clock FIFO buffering host weight writes; DEPTH must be a power of 2
// and at least 2. Read data is the current head, valid whenever !empty.
module coupling_prog_ctrl_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + 1'b1;
      if (pop  && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/coupling_prog_ctrl.sv
// Programming/run sequencer for the DIMPLE coupling matrix. Defining
// COUPLE_RDBACK_EN adds an rdata read-back check after every column write.
module coupling_prog_ctrl
  import coupling_prog_ctrl_pkg::*;
#(
  parameter int N          = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int WR_HOLD    = 2,
  parameter int RUN_W      = 32
) (
  input  logic             clk,
  input  logic             axi_rst,
  input  logic             hw_valid,
  output logic             hw_ready,
  input  logic [15:0]      hw_s_addr,
  input  logic [15:0]      hw_d_addr,
  input  logic [31:0]      hw_wdata,
  input  logic             start,
  input  logic             abort,
  input  logic [RUN_W-1:0] run_cycles,
  input  logic             err_clr,
  output logic             wready,
  output logic [N-2:0]     col_sel,
  output logic [15:0]      s_addr,
  output logic [15:0]      d_addr,
  output logic [31:0]      wdata,
  output logic             ising_rstn,
  output logic             busy,
  output logic             done,
  output logic             err_addr
`ifdef COUPLE_RDBACK_EN
  ,
  input  logic [31:0]      rdata,
  output logic             err_rdback
`endif
);

  localparam int HOLD_W = (WR_HOLD > 1) ? $clog2(WR_HOLD) : 1;

  logic [2:0]        state;
  logic [HOLD_W-1:0] hold_cnt;
  logic [RUN_W-1:0]  run_cnt;
  logic              start_pending;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_push;
  logic              fifo_pop;
  logic [63:0]       fifo_wdata;
  logic [63:0]       fifo_rdata;
  col_dec_t          dec;
  logic [N-2:0]      dec_onehot;

  assign fifo_push  = hw_valid && !fifo_full;
  assign fifo_pop   = (state == S_LOAD);
  assign fifo_wdata = {hw_s_addr, hw_d_addr, hw_wdata};
  assign hw_ready   = !fifo_full;

  coupling_prog_ctrl_sync_fifo #(
    .WIDTH (64),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (axi_rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign dec        = col_decode(fifo_rdata[63:48], fifo_rdata[47:32], N);
  assign dec_onehot = {{(N-2){1'b0}}, 1'b1} << dec.k;

  // Pending writes always drain before a run starts, so the array is never
  // written while the oscillators are released.
  always_ff @(posedge clk or posedge axi_rst) begin
    if (axi_rst) begin
      state    <= S_IDLE;
      hold_cnt <= '0;
      run_cnt  <= '0;
      col_sel  <= '0;
      s_addr   <= '0;
      d_addr   <= '0;
      wdata    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            state <= S_LOAD;
          end else if (start || start_pending) begin
            run_cnt <= run_cycles;
            state   <= (run_cycles == '0) ? S_STOP : S_RUN;
          end
        end
        S_LOAD: begin
          s_addr  <= fifo_rdata[63:48];
          d_addr  <= fifo_rdata[47:32];
          wdata   <= fifo_rdata[31:0];
          col_sel <= dec.valid ? dec_onehot : '0;
          state   <= dec.valid ? S_WRITE : S_IDLE;
        end
        S_WRITE: begin
          col_sel  <= '0;
          hold_cnt <= HOLD_W'(WR_HOLD - 1);
          state    <= S_HOLD;
        end
        S_HOLD: begin
          if (hold_cnt == '0) begin
`ifdef COUPLE_RDBACK_EN
            state <= S_VERIFY;
`else
            state <= S_IDLE;
`endif
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
`ifdef COUPLE_RDBACK_EN
        S_VERIFY: state <= S_IDLE;
`endif
        S_RUN: begin
          if (abort || run_cnt <= RUN_W'(1)) state <= S_STOP;
          else                               run_cnt <= run_cnt - 1'b1;
        end
        S_STOP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // At most one run is remembered; starts during RUN/STOP are dropped.
  always_ff @(posedge clk or posedge axi_rst) begin
    if (axi_rst)
      start_pending <= 1'b0;
    else if (state == S_IDLE && fifo_empty && (start || start_pending))
      start_pending <= 1'b0;
    else if (start && state != S_RUN && state != S_STOP)
      start_pending <= 1'b1;
  end

  always_ff @(posedge clk or posedge axi_rst) begin
    if (axi_rst)                          err_addr <= 1'b0;
    else if (state == S_LOAD && !dec.valid) err_addr <= 1'b1;
    else if (err_clr)                     err_addr <= 1'b0;
  end

`ifdef COUPLE_RDBACK_EN
  always_ff @(posedge clk or posedge axi_rst) begin
    if (axi_rst)                             err_rdback <= 1'b0;
    else if (state == S_VERIFY && rdata != wdata) err_rdback <= 1'b1;
    else if (err_clr)                        err_rdback <= 1'b0;
  end
`endif

  assign wready     = (state == S_WRITE);
  assign ising_rstn = (state == S_RUN);
  assign done       = (state == S_STOP);
  assign busy       = (state != S_IDLE) || !fifo_empty || start_pending;

endmodule

// File: tb/tb_coupling_prog_ctrl.sv
// Directed bench for coupling_prog_ctrl (N=8, FIFO_DEPTH=8, WR_HOLD=2).
module tb_coupling_prog_ctrl;

  localparam int N = 8;

  logic        clk;
  logic        axi_rst;
  logic        hw_valid;
  logic        hw_ready;
  logic [15:0] hw_s_addr;
  logic [15:0] hw_d_addr;
  logic [31:0] hw_wdata;
  logic        start;
  logic        abort;
  logic [31:0] run_cycles;
  logic        err_clr;
  logic        wready;
  logic [N-2:0] col_sel;
  logic [15:0] s_addr;
  logic [15:0] d_addr;
  logic [31:0] wdata;
  logic        ising_rstn;
  logic        busy;
  logic        done;
  logic        err_addr;
`ifdef COUPLE_RDBACK_EN
  logic [31:0] rdata;
  logic        err_rdback;
  assign rdata = wdata;
`endif

  coupling_prog_ctrl #(
    .N          (N),
    .FIFO_DEPTH (8),
    .WR_HOLD    (2),
    .RUN_W      (32)
  ) dut (
    .clk        (clk),
    .axi_rst    (axi_rst),
    .hw_valid   (hw_valid),
    .hw_ready   (hw_ready),
    .hw_s_addr  (hw_s_addr),
    .hw_d_addr  (hw_d_addr),
    .hw_wdata   (hw_wdata),
    .start      (start),
    .abort      (abort),
    .run_cycles (run_cycles),
    .err_clr    (err_clr),
    .wready     (wready),
    .col_sel    (col_sel),
    .s_addr     (s_addr),
    .d_addr     (d_addr),
    .wdata      (wdata),
    .ising_rstn (ising_rstn),
    .busy       (busy),
    .done       (done),
    .err_addr   (err_addr)
`ifdef COUPLE_RDBACK_EN
    ,
    .rdata      (rdata),
    .err_rdback (err_rdback)
`endif
  );

  typedef struct {
    logic [15:0] s;
    logic [15:0] d;
    logic [31:0] w;
    logic        valid;
    logic [6:0]  col;
  } wr_vec_t;

  wr_vec_t     vec [10];
  int          checks = 0;
  int          failures = 0;
  int          first;
  int          pulses;
  int          highs;
  int          dones;
  int          done_at;
  int          first_high;
  int          wr_at [16];
  logic [15:0] cap_s [16];
  logic [15:0] cap_d [16];
  logic [31:0] cap_w [16];
  logic [6:0]  cap_c [16];
  logic [6:0]  got_col;
  logic [15:0] got_s;
  logic [15:0] got_d;
  logic [31:0] got_w;
  int          run_wr;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] s, input logic [15:0] d,
                               input logic [31:0] w);
    hw_valid  = 1'b1;
    hw_s_addr = s;
    hw_d_addr = d;
    hw_wdata  = w;
  endtask

  task automatic pulseStart(input logic [31:0] cycles);
    run_cycles = cycles;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    vec[0] = '{16'd1, 16'd4,   32'h0000_0005, 1'b1, 7'b0000100};
    vec[1] = '{16'd6, 16'd1,   32'h1234_5678, 1'b1, 7'b0000100};
    vec[2] = '{16'd3, 16'd3,   32'h0000_0033, 1'b0, 7'b0000000};
    vec[3] = '{16'd0, 16'd1,   32'hCAFE_0001, 1'b1, 7'b0000001};
    vec[4] = '{16'd1, 16'd0,   32'hCAFE_0002, 1'b1, 7'b1000000};
    vec[5] = '{16'd8, 16'd1,   32'h0000_0088, 1'b0, 7'b0000000};
    vec[6] = '{16'd7, 16'd5,   32'hCAFE_0003, 1'b1, 7'b0100000};
    vec[7] = '{16'd2, 16'd7,   32'hCAFE_0004, 1'b1, 7'b0010000};
    vec[8] = '{16'd0, 16'd200, 32'h0000_00C8, 1'b0, 7'b0000000};
    vec[9] = '{16'd4, 16'd0,   32'hCAFE_0005, 1'b1, 7'b0001000};

    axi_rst = 1'b1; hw_valid = 1'b0; hw_s_addr = '0; hw_d_addr = '0;
    hw_wdata = '0; start = 1'b0; abort = 1'b0; run_cycles = '0; err_clr = 1'b0;
    tick(); tick();
    checkOutput("rst_wready", wready, 0);
    checkOutput("rst_col_sel", col_sel, 0);
    checkOutput("rst_s_addr", s_addr, 0);
    checkOutput("rst_d_addr", d_addr, 0);
    checkOutput("rst_wdata", wdata, 0);
    checkOutput("rst_ising_rstn", ising_rstn, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_err_addr", err_addr, 0);
    checkOutput("rst_hw_ready", hw_ready, 1);
    axi_rst = 1'b0;
    tick();

    // Single writes: latency, decoded column, registered data, error flag.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vec[i].s, vec[i].d, vec[i].w);
      tick();
      hw_valid = 1'b0;
      first = -1; pulses = 0; got_col = '0; got_s = '0; got_d = '0; got_w = '0;
      for (int n = 0; n < 8; n++) begin
        if (wready === 1'b1) begin
          pulses++;
          if (first < 0) begin
            first = n; got_col = col_sel; got_s = s_addr; got_d = d_addr; got_w = wdata;
          end
        end
        if (first >= 0 && n == first + 1) checkOutput($sformatf("v%0d_hold_col", i), col_sel, 0);
        tick();
      end
      checkOutput($sformatf("v%0d_pulses", i), pulses, vec[i].valid ? 1 : 0);
      checkOutput($sformatf("v%0d_latency", i), first, vec[i].valid ? 2 : -1);
      if (vec[i].valid) begin
        checkOutput($sformatf("v%0d_col_sel", i), got_col, vec[i].col);
        checkOutput($sformatf("v%0d_s_addr", i), got_s, vec[i].s);
        checkOutput($sformatf("v%0d_d_addr", i), got_d, vec[i].d);
        checkOutput($sformatf("v%0d_wdata", i), got_w, vec[i].w);
      end
      checkOutput($sformatf("v%0d_busy", i), busy, 0);
      checkOutput($sformatf("v%0d_err_addr", i), err_addr, !vec[i].valid);
      if (!vec[i].valid) begin
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checkOutput($sformatf("v%0d_err_clr", i), err_addr, 0);
      end
    end

    // Run of 10 cycles.
    pulseStart(32'd10);
    highs = 0; dones = 0; done_at = -1;
    for (int n = 0; n < 30; n++) begin
      if (ising_rstn === 1'b1) highs++;
      if (done === 1'b1) begin dones++; done_at = n; end
      tick();
    end
    checkOutput("run10_highs", highs, 10);
    checkOutput("run10_dones", dones, 1);
    checkOutput("run10_done_at", done_at, 10);

    // Zero-length run.
    pulseStart(32'd0);
    highs = 0; dones = 0;
    for (int n = 0; n < 10; n++) begin
      if (ising_rstn === 1'b1) highs++;
      if (done === 1'b1) dones++;
      tick();
    end
    checkOutput("run0_highs", highs, 0);
    checkOutput("run0_dones", dones, 1);

    // Abort three cycles into a run.
    pulseStart(32'd100);
    tick(); tick();
    checkOutput("abort_pre_high", ising_rstn, 1);
    abort = 1'b1;
    tick();
    checkOutput("abort_rstn_low", ising_rstn, 0);
    checkOutput("abort_done", done, 1);
    abort = 1'b0;
    tick();
    checkOutput("abort_done_once", done, 0);
    checkOutput("abort_idle", busy, 0);

    // Start arriving while writes are still pending.
    applyStimulus(16'd0, 16'd2, 32'h0000_0A01);
    tick();
    applyStimulus(16'd5, 16'd3, 32'h0000_0A02);
    tick();
    hw_valid = 1'b0;
    pulseStart(32'd3);
    pulses = 0; first_high = -1; highs = 0; dones = 0;
    for (int n = 0; n < 40; n++) begin
      if (wready === 1'b1 && pulses < 16) begin wr_at[pulses] = n; pulses++; end
      if (ising_rstn === 1'b1) begin
        highs++;
        if (first_high < 0) first_high = n;
      end
      if (done === 1'b1) dones++;
      tick();
    end
    checkOutput("pend_pulses", pulses, 2);
    checkOutput("pend_spacing", wr_at[1] - wr_at[0], 5);
    checkOutput("pend_run_gap", first_high - wr_at[1], 4);
    checkOutput("pend_highs", highs, 3);
    checkOutput("pend_dones", dones, 1);

    // Fill the FIFO during a long run, then drain it in order.
    pulseStart(32'd40);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("fill%0d_ready", i), hw_ready, 1);
      applyStimulus(16'(i), 16'((i + 1) % 8), 32'hA0 + 32'(i));
      tick();
    end
    checkOutput("fill_full", hw_ready, 0);
    applyStimulus(16'd7, 16'd6, 32'hDEAD);
    tick(); tick();
    hw_valid = 1'b0;
    checkOutput("fill_still_full", hw_ready, 0);
    pulses = 0; run_wr = 0;
    for (int n = 0; n < 120; n++) begin
      if (wready === 1'b1 && ising_rstn === 1'b1) run_wr++;
      if (wready === 1'b1 && pulses < 16) begin
        wr_at[pulses] = n; cap_s[pulses] = s_addr; cap_d[pulses] = d_addr;
        cap_w[pulses] = wdata; cap_c[pulses] = col_sel; pulses++;
      end
      tick();
    end
    checkOutput("drain_run_writes", run_wr, 0);
    checkOutput("drain_pulses", pulses, 8);
    checkOutput("drain_idle", busy, 0);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("drain%0d_s", i), cap_s[i], 16'(i));
      checkOutput($sformatf("drain%0d_d", i), cap_d[i], 16'((i + 1) % 8));
      checkOutput($sformatf("drain%0d_w", i), cap_w[i], 32'hA0 + 32'(i));
      checkOutput($sformatf("drain%0d_col", i), cap_c[i], 7'b0000001);
      if (i > 0) checkOutput($sformatf("drain%0d_gap", i), wr_at[i] - wr_at[i-1], 5);
    end

    // Asynchronous reset in the middle of a run.
    pulseStart(32'd100);
    applyStimulus(16'd1, 16'd2, 32'h0000_0B01);
    tick();
    applyStimulus(16'd2, 16'd3, 32'h0000_0B02);
    tick();
    hw_valid = 1'b0;
    tick();
    checkOutput("rstrun_pre_high", ising_rstn, 1);
    checkOutput("rstrun_pre_busy", busy, 1);
    #2 axi_rst = 1'b1;
    #1;
    checkOutput("rstrun_rstn", ising_rstn, 0);
    checkOutput("rstrun_hw_ready", hw_ready, 1);
    checkOutput("rstrun_busy", busy, 0);
    checkOutput("rstrun_done", done, 0);
    tick();
    axi_rst = 1'b0;
    dones = 0; pulses = 0; highs = 0;
    for (int n = 0; n < 20; n++) begin
      if (done === 1'b1) dones++;
      if (wready === 1'b1) pulses++;
      if (ising_rstn === 1'b1) highs++;
      tick();
    end
    checkOutput("rstrun_no_done", dones, 0);
    checkOutput("rstrun_no_write", pulses, 0);
    checkOutput("rstrun_no_run", highs, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/coupling_prog_ctrl.md
Name: coupling_prog_ctrl

Overview:
Sequencer that owns the programming and run phases of the DIMPLE coupling matrix. It buffers host weight writes in a FIFO, decodes each (s_addr, d_addr) pair to its coupled column, and drives the column write strobes. It then gates ising_rstn for a programmed anneal window. It sits between the host/AXI register front end and the array of coupled columns. No weight write is ever issued while the oscillators run.

Parameters:
N, 8, number of spins/wires; must be even and at least 4.
FIFO_DEPTH, 8, host write FIFO entries; must be a power of 2.
WR_HOLD, 2, idle cycles after each wready pulse before the next write or run, for cell settling; at least 1.
RUN_W, 32, width of run_cycles and the run counter.

Ports:
clk  in  1  system clock
axi_rst  in  1  asynchronous active-high reset
hw_valid  in  1  host write request valid
hw_ready  out  1  FIFO not full
hw_s_addr  in  16  source spin index
hw_d_addr  in  16  destination spin index
hw_wdata  in  32  weight word
start  in  1  pulse; request an anneal run
abort  in  1  level; terminate the current run
run_cycles  in  RUN_W  anneal length; sampled when RUN is entered
err_clr  in  1  pulse; clears err_addr
wready  out  1  one-cycle write strobe to the columns
col_sel  out  N-1  one-hot column wr_match vector
s_addr  out  16  registered source address
d_addr  out  16  registered destination address
wdata  out  32  registered weight
ising_rstn  out  1  oscillator array reset; active low; high only in RUN
busy  out  1  state is not IDLE, or FIFO is not empty, or a start is pending
done  out  1  one-cycle pulse at the end of a run
err_addr  out  1  sticky flag; an invalid address was dropped

Behaviour:
- Reset (asynchronous, axi_rst=1): FIFO emptied; state IDLE; start_pending cleared. Output reset values: wready=0, col_sel=0, s_addr=0, d_addr=0, wdata=0, ising_rstn=0, busy=0, done=0, err_addr=0. hw_ready=1. Reset in the middle of a run drops ising_rstn to 0 immediately; no done pulse is produced.
- FIFO: push when hw_valid && hw_ready; hw_ready = !full. A simultaneous push and pop when full is not allowed, because hw_ready is already low.
- Column decode: K = (d_addr - s_addr - 1) mod N; col_sel[K] = 1.
  - Invalid when s_addr == d_addr, s_addr >= N, or d_addr >= N.
  - An invalid entry is popped and dropped, and err_addr is set. If err_clr and a new error occur in the same cycle, the set wins.
- States:
  - IDLE:
    - If the FIFO is not empty, go to LOAD. Writes take priority over start.
    - Otherwise, if start or start_pending is set, go to RUN: load the counter from run_cycles and clear start_pending.
  - LOAD: pop the FIFO and register the address, data and col_sel.
    - Valid entry: go to WRITE.
    - Invalid entry: return to IDLE.
  - WRITE: wready=1 for exactly one cycle with col_sel and data stable; go to HOLD.
  - HOLD: wait WR_HOLD cycles with wready=0 and col_sel=0; go to IDLE.
  - RUN: ising_rstn=1; the counter decrements each cycle.
    - Counter reaching 1, or abort=1: go to STOP.
    - Host pushes during RUN are buffered only, never issued.
  - STOP: ising_rstn=0; done=1 for one cycle; go to IDLE.
- start received in any state other than IDLE sets start_pending. A start received while a run is already pending or active is ignored (no queueing beyond one).
- run_cycles == 0: RUN is skipped; go directly to STOP, so ising_rstn stays 0 and done is asserted.
- Latency: an entry accepted at cycle t gives earliest wready at t+2. Back-to-back writes are spaced 3+WR_HOLD cycles apart.
- A run of R cycles holds ising_rstn high for exactly R cycles.

Optional Feature:
Macro: COUPLE_RDBACK_EN.
- Defined: adds input rdata[31:0] and a VERIFY state after HOLD.
  - VERIFY compares rdata against the registered wdata.
  - On mismatch, the sticky output err_rdback is set and cleared by err_clr.
  - Adds one cycle per write.
- Undefined: no rdata port, no VERIFY state; err_rdback is absent.

Decomposition:
- Shared package: state encoding localparams (IDLE, LOAD, WRITE, HOLD, RUN, STOP, VERIFY) and the column-decode function (addr pair to K plus valid flag). Both are reused by the bench model.
- One natural sub-module: sync_fifo (width 64 = s, d and wdata; depth FIFO_DEPTH; signals push, pop, full, empty).

Test Plan:
- N=8: write s=1, d=4, wdata=0x5 → wready pulse 2 cycles after acceptance; col_sel=0b0000100 (K=2); s_addr=1, d_addr=4, wdata=0x5.
- Wrap-around: s=6, d=1 → K=(1-6-1) mod 8=2, so col_sel bit 2; s=3, d=3 → dropped, err_addr=1, no wready; err_clr → err_addr=0.
- Fill 8 entries with no pops (start a long run first) → hw_ready=0 on the 8th; after the run, all 8 wready pulses occur in FIFO order, each 3+WR_HOLD=5 cycles apart.
- start with run_cycles=10 → ising_rstn high for exactly 10 cycles, then a done pulse; run_cycles=0 → done with ising_rstn never high.
- abort 3 cycles into RUN → ising_rstn low on the next cycle, then done; start issued during pending writes → run begins only after the last HOLD.
- axi_rst asserted during RUN → ising_rstn=0 asynchronously, FIFO empty, no done pulse, hw_ready=1.
